uart_interval_frame_tx: RTL and testbench

Encoder and transmitter for the 5-byte interval command frame. Frame byte order is HDR0 HDR1 INT_HI INT_LO TAIL.
- TAIL=CC: enable, with a 16-bit interval.
- TAIL=BB: disable.
The block sits between control logic and a byte-wide UART transmitter. It captures one command request, then feeds the frame bytes to the UART one at a time, using a ready/strobe handshake and a programmable inter-byte gap.
The far-end receiver reassembles the interval as {INT_HI, INT_LO}.

---
 rtl/uart_interval_pkg.sv | 54 +++++
 rtl/uart_interval_frame_tx.sv | 141 ++++++++++++++
 tb/tb_uart_interval_frame_tx.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_interval_pkg.sv
// ---------------------------------------------------------------------------
// uart_interval_pkg
//
// Shared definitions for the 5-byte interval command frame:
//     HDR0 HDR1 INT_HI INT_LO TAIL
// The transmitter (uart_interval_frame_tx) and the far-end receiver both use
// these constants, so the frame format is defined in exactly one place.
//
// Contents:
//     HDR0, HDR1         header bytes that open every frame
//     TAIL_ON, TAIL_OFF  tail byte for enable / disable commands
//     FRAME_LEN          number of bytes in a frame
//     state_t            transmitter FSM states
//     byte_idx_t         index of the byte currently being sent
//     frame_byte()       byte mux: frame position -> byte value
// ---------------------------------------------------------------------------
package uart_interval_pkg;

    localparam logic [7:0] HDR0     = 8'hEE;
    localparam logic [7:0] HDR1     = 8'hDD;
    localparam logic [7:0] TAIL_ON  = 8'hCC;
    localparam logic [7:0] TAIL_OFF = 8'hBB;
    localparam int         FRAME_LEN = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_RDY,
        ST_SEND,
        ST_GAP
    } state_t;

    typedef logic [2:0] byte_idx_t;

    localparam byte_idx_t LAST_IDX = byte_idx_t'(FRAME_LEN - 1);

    // Payload bytes go out verbatim; a header-like interval (e.g. 16'hEEDD)
    // is not escaped; the receiver resynchronises on the HDR0/HDR1 pair.
    function automatic logic [7:0] frame_byte(input byte_idx_t   idx,
                                              input logic        en,
                                              input logic [15:0] interval);
        logic [7:0] b;
        b = 8'h00;
        case (idx)
            3'd0:    b = HDR0;
            3'd1:    b = HDR1;
            3'd2:    b = interval[15:8];
            3'd3:    b = interval[7:0];
            3'd4:    b = en ? TAIL_ON : TAIL_OFF;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_interval_frame_tx.sv
// ---------------------------------------------------------------------------
// uart_interval_frame_tx
//
// Captures one interval command and feeds its 5-byte frame to a byte-wide
// UART transmitter, one byte per ready/strobe handshake, with a programmable
// idle gap after every strobe.
//
// Parameters:
//     GAP_CYCLES    idle clk cycles after each strobe (1..65535)
//
// Ports:
//     clk           system clock
//     rst_n         synchronous active-low reset
//     req           command request, sampled only while idle
//     req_enable    1 = enable frame (TAIL_ON), 0 = disable frame (TAIL_OFF)
//     req_interval  16-bit interval, used only for enable frames
//     busy          high from the cycle after acceptance until frame end
//     done          one-cycle pulse when the last byte's gap expires
//     tx_data       byte presented to the UART, qualified by tx_wen
//     tx_wen        one-cycle write strobe to the UART
//     tx_ready      UART can accept a byte
//
// All outputs are registered. With tx_ready held high, strobes are spaced
// GAP_CYCLES+2 cycles apart (SEND + GAP + WAIT_RDY).
// ---------------------------------------------------------------------------
module uart_interval_frame_tx
    import uart_interval_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        req_enable,
    input  logic [15:0] req_interval,
    output logic        busy,
    output logic        done,
    output logic [7:0]  tx_data,
    output logic        tx_wen,
    input  logic        tx_ready
);

    // The counter runs GAP_CYCLES-1 down to 0, so GAP lasts GAP_CYCLES cycles.
    localparam logic [15:0] GAP_LOAD = 16'(GAP_CYCLES - 1);

    state_t      state_q, state_d;
    byte_idx_t   idx_q,   idx_d;
    logic [15:0] gap_q,   gap_d;
    logic        en_q,    en_d;
    logic [15:0] int_q,   int_d;
    logic        busy_d;
    logic        done_d;
    logic [7:0]  tx_data_d;
    logic        tx_wen_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            gap_q   <= '0;
            en_q    <= 1'b0;
            int_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            tx_data <= 8'h00;
            tx_wen  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            en_q    <= en_d;
            int_q   <= int_d;
            busy    <= busy_d;
            done    <= done_d;
            tx_data <= tx_data_d;
            tx_wen  <= tx_wen_d;
        end
    end

    // Next-state and next-output logic. Outputs are computed one cycle ahead
    // so that tx_wen is high exactly while the FSM sits in SEND, and done/busy
    // change on the same edge that returns the FSM to IDLE.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        gap_d     = gap_q;
        en_d      = en_q;
        int_d     = int_q;
        busy_d    = busy;
        done_d    = 1'b0;
        tx_data_d = tx_data;
        tx_wen_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    en_d    = req_enable;
                    // A disable frame always carries 00 00 as its interval.
                    int_d   = req_enable ? req_interval : 16'h0000;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_WAIT_RDY;
                end
            end

            ST_WAIT_RDY: begin
                // tx_ready is only looked at here; no timeout.
                if (tx_ready) begin
                    tx_wen_d  = 1'b1;
                    tx_data_d = frame_byte(idx_q, en_q, int_q);
                    state_d   = ST_SEND;
                end
            end

            ST_SEND: begin
                gap_d   = GAP_LOAD;
                state_d = ST_GAP;
            end

            ST_GAP: begin
                if (gap_q == 16'd0) begin
                    if (idx_q == LAST_IDX) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + byte_idx_t'(1);
                        state_d = ST_WAIT_RDY;
                    end
                end else begin
                    gap_d = gap_q - 16'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_interval_frame_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_interval_frame_tx
//
// Two transmitters are instantiated: index 0 with GAP_CYCLES=4 and index 1
// with GAP_CYCLES=1. Stimulus pushes the expected frame bytes and the
// expected decoded command into per-instance queues; a monitor per instance
// pops and compares on every tx_wen strobe and also runs a small far-end
// receiver model that decodes frames from the strobed byte stream.
//
// Timing convention: cyc counts posedges. A strobe or done seen at a negedge
// is stamped cyc+1, the edge at which the UART (or control logic) samples it.
// A request driven after a negedge is accepted at edge cyc+1.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_interval_frame_tx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_v;
    logic [1:0]  req_enable_v;
    logic [1:0]  tx_ready_v;
    logic [15:0] req_interval_v [2];
    wire  [1:0]  busy_v;
    wire  [1:0]  done_v;
    wire  [1:0]  tx_wen_v;
    wire  [7:0]  tx_data_v [2];

    int cyc    = 0;
    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0]  exp_bytes    [2][$];
    logic [16:0] exp_frames   [2][$];
    int          strobe_times [2][$];
    int          frame_base   [2];
    int          accept_edge  [2];
    int          done_edge    [2];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    uart_interval_frame_tx #(.GAP_CYCLES(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req_v[0]),
        .req_enable   (req_enable_v[0]),
        .req_interval (req_interval_v[0]),
        .busy         (busy_v[0]),
        .done         (done_v[0]),
        .tx_data      (tx_data_v[0]),
        .tx_wen       (tx_wen_v[0]),
        .tx_ready     (tx_ready_v[0])
    );

    uart_interval_frame_tx #(.GAP_CYCLES(1)) dut_gap1 (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req_v[1]),
        .req_enable   (req_enable_v[1]),
        .req_interval (req_interval_v[1]),
        .busy         (busy_v[1]),
        .done         (done_v[1]),
        .tx_data      (tx_data_v[1]),
        .tx_wen       (tx_wen_v[1]),
        .tx_ready     (tx_ready_v[1])
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic reportFail(input string name, input string what);
        n_cmp++;
        n_fail++;
        $display("[TB] FAIL %s: actual=%s required=none", name, what);
    endtask

    // Scoreboard monitor plus far-end receiver model, one per instance.
    for (genvar k = 0; k < 2; k++) begin : g_mon
        logic        prev_wen  = 1'b0;
        logic        prev_done = 1'b0;
        logic [7:0]  win [5]   = '{default: 8'h00};
        logic [16:0] decoded;

        always @(negedge clk) begin
            if (done_v[k] === 1'b1)
                checkOutput($sformatf("done_pulse%0d", k), 32'(prev_done), 32'd0);
            if (tx_wen_v[k] === 1'b1) begin
                strobe_times[k].push_back(cyc + 1);
                checkOutput($sformatf("wen_pulse%0d", k), 32'(prev_wen), 32'd0);
                if (exp_bytes[k].size() == 0)
                    reportFail($sformatf("tx_byte%0d", k), "unexpected_strobe");
                else
                    checkOutput($sformatf("tx_byte%0d", k), 32'(tx_data_v[k]),
                                32'(exp_bytes[k].pop_front()));
                for (int i = 0; i < 4; i++) win[i] = win[i + 1];
                win[4] = tx_data_v[k];
                if (win[0] == 8'hEE && win[1] == 8'hDD &&
                    (win[4] == 8'hCC || win[4] == 8'hBB)) begin
                    decoded = {win[4] == 8'hCC, win[2], win[3]};
                    if (exp_frames[k].size() == 0)
                        reportFail($sformatf("rx_frame%0d", k), "unexpected_frame");
                    else
                        checkOutput($sformatf("rx_frame%0d", k), 32'(decoded),
                                    32'(exp_frames[k].pop_front()));
                end
            end
            prev_wen  = tx_wen_v[k];
            prev_done = done_v[k];
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int k, input logic en, input logic [15:0] interval);
        logic [15:0] payload;
        payload = en ? interval : 16'h0000;
        exp_bytes[k].push_back(8'hEE);
        exp_bytes[k].push_back(8'hDD);
        exp_bytes[k].push_back(payload[15:8]);
        exp_bytes[k].push_back(payload[7:0]);
        exp_bytes[k].push_back(en ? 8'hCC : 8'hBB);
        exp_frames[k].push_back({en, payload});
        frame_base[k]     = strobe_times[k].size();
        req_v[k]          = 1'b1;
        req_enable_v[k]   = en;
        req_interval_v[k] = interval;
        accept_edge[k]    = cyc + 1;
        tick();
        req_v[k] = 1'b0;
        checkOutput("busy_after_accept", 32'(busy_v[k]), 32'd1);
    endtask

    task automatic waitDone(input int k, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (done_v[k] === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            reportFail("done_wait", "timeout");
        end else begin
            done_edge[k] = cyc + 1;
            checkOutput("busy_at_done", 32'(busy_v[k]), 32'd0);
        end
    endtask

    task automatic waitStrobes(input int k, input int n, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (strobe_times[k].size() >= frame_base[k] + n) seen = 1'b1;
        end
        if (!seen) reportFail("strobe_wait", "timeout");
    endtask

    // Strobes at accept+2, spaced gap+2, done gap+1 after the last strobe.
    // skip names a byte whose spacing from its predecessor is not checked.
    task automatic checkFrameTiming(input int k, input int gap, input int skip);
        int b;
        int n;
        b = frame_base[k];
        n = strobe_times[k].size() - b;
        checkOutput("strobe_count", 32'(n), 32'd5);
        if (n >= 5) begin
            checkOutput("first_strobe", 32'(strobe_times[k][b]), 32'(accept_edge[k] + 2));
            for (int i = 1; i < 5; i++)
                if (i != skip)
                    checkOutput($sformatf("strobe_spacing%0d", i),
                                32'(strobe_times[k][b + i] - strobe_times[k][b + i - 1]),
                                32'(gap + 2));
            checkOutput("done_delay", 32'(done_edge[k] - strobe_times[k][b + 4]), 32'(gap + 1));
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int rise;
        rst_n             = 1'b0;
        req_v             = 2'b00;
        req_enable_v      = 2'b00;
        tx_ready_v        = 2'b11;
        req_interval_v[0] = 16'h0000;
        req_interval_v[1] = 16'h0000;
        frame_base        = '{0, 0};
        accept_edge       = '{0, 0};
        done_edge         = '{0, 0};
        repeat (3) tick();

        $display("[TB] reset state");
        checkOutput("rst_busy",    32'(busy_v[0]),    32'd0);
        checkOutput("rst_done",    32'(done_v[0]),    32'd0);
        checkOutput("rst_tx_wen",  32'(tx_wen_v[0]),  32'd0);
        checkOutput("rst_tx_data", 32'(tx_data_v[0]), 32'h00);
        checkOutput("rst_busy1",   32'(busy_v[1]),    32'd0);
        rst_n = 1'b1;
        tick();

        $display("[TB] enable frame 1234");
        applyStimulus(0, 1'b1, 16'h1234);
        waitDone(0, 200);
        checkFrameTiming(0, 4, -1);
        tick();
        checkOutput("done_low_after", 32'(done_v[0]), 32'd0);

        $display("[TB] disable frame ABCD");
        applyStimulus(0, 1'b0, 16'hABCD);
        waitDone(0, 200);
        checkFrameTiming(0, 4, -1);
        tick();

        $display("[TB] backpressure before byte 2");
        applyStimulus(0, 1'b1, 16'h1234);
        waitStrobes(0, 2, 100);
        tx_ready_v[0] = 1'b0;
        repeat (20) begin
            tick();
            checkOutput("bp_tx_wen", 32'(tx_wen_v[0]), 32'd0);
            checkOutput("bp_busy",   32'(busy_v[0]),   32'd1);
        end
        tx_ready_v[0] = 1'b1;
        rise = cyc + 1;
        waitStrobes(0, 3, 20);
        if (strobe_times[0].size() >= frame_base[0] + 3)
            checkOutput("bp_resume", 32'(strobe_times[0][frame_base[0] + 2]), 32'(rise + 1));
        waitDone(0, 200);
        checkFrameTiming(0, 4, 2);
        tick();

        $display("[TB] request handling");
        applyStimulus(0, 1'b1, 16'h0005);
        waitStrobes(0, 2, 100);
        req_v[0]          = 1'b1;
        req_enable_v[0]   = 1'b0;
        req_interval_v[0] = 16'hFFFF;
        repeat (3) begin
            tick();
            checkOutput("busy_midframe", 32'(busy_v[0]), 32'd1);
        end
        req_v[0] = 1'b0;
        waitDone(0, 200);
        checkFrameTiming(0, 4, -1);
        applyStimulus(0, 1'b0, 16'h0777);
        waitDone(0, 200);
        checkFrameTiming(0, 4, -1);
        tick();

        $display("[TB] reset mid-frame");
        applyStimulus(0, 1'b1, 16'h1234);
        waitStrobes(0, 2, 100);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checkOutput("midrst_busy",    32'(busy_v[0]),    32'd0);
        checkOutput("midrst_tx_wen",  32'(tx_wen_v[0]),  32'd0);
        checkOutput("midrst_tx_data", 32'(tx_data_v[0]), 32'h00);
        checkOutput("midrst_done",    32'(done_v[0]),    32'd0);
        exp_bytes[0].delete();
        void'(exp_frames[0].pop_back());
        repeat (10) tick();
        applyStimulus(0, 1'b1, 16'h4321);
        waitDone(0, 200);
        checkFrameTiming(0, 4, -1);
        checkOutput("rx_pending0", 32'(exp_frames[0].size()), 32'd0);

        $display("[TB] loopback with GAP_CYCLES=1");
        applyStimulus(1, 1'b1, 16'hFFFF);
        waitDone(1, 100);
        checkFrameTiming(1, 1, -1);
        tick();
        applyStimulus(1, 1'b1, 16'hEEDD);
        waitDone(1, 100);
        checkFrameTiming(1, 1, -1);
        checkOutput("rx_pending1", 32'(exp_frames[1].size()), 32'd0);
        repeat (3) tick();

        checkOutput("bytes_left0", 32'(exp_bytes[0].size()), 32'd0);
        checkOutput("bytes_left1", 32'(exp_bytes[1].size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
